// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;
  localparam int DATA_W  = 64;
  localparam int REG_W   = 5;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {IDLE, BUSY, ERROR} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sdata;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              is_byte;
  } exmem_t;

  function automatic logic [DATA_W-1:0] zext_byte(input logic [DATA_W-1:0] v);
    return {{(DATA_W-8){1'b0}}, v[7:0]};
  endfunction
endpackage

// File: rtl/mem_timeout_counter.sv
// Counts unacknowledged request cycles; expire fires on the TIMEOUT-th one.
module mem_timeout_counter
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic count,
  input  logic clear,
  output logic expire
);
  logic [CNT_W-1:0] cnt;

  // The 16th waiting cycle is the one that sees cnt==15 while still counting.
  assign expire = count && !clear && (cnt == CNT_W'(TIMEOUT-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else if (count) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers, memory handshake FSM, timeout.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_result_ex,
  input  logic [DATA_W-1:0] store_data_ex,
  input  logic [REG_W-1:0]  rd_ex,
  input  logic              reg_write_ex,
  input  logic              mem_read_ex,
  input  logic              mem_write_ex,
  input  logic              byte_ex,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] alu_result_mem,
  output logic [REG_W-1:0]  rd_mem,
  output logic              reg_write_mem,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  rd_wb,
  output logic              reg_write_wb,
  output logic              stall,
  output logic              mem_err
);
  exmem_t            em;
  state_t            state;
  logic              mem_op, is_load, ack, expire;
  logic [DATA_W-1:0] load_data;

  assign mem_op    = em.mem_read | em.mem_write;
  assign is_load   = em.mem_read & ~em.mem_write;  // read+write behaves as a store
  assign mem_req   = mem_op && (state != ERROR);
  assign ack       = mem_req && mem_ack;
  assign stall     = (mem_req && !mem_ack) || (state == ERROR);
  assign load_data = em.is_byte ? zext_byte(mem_rdata) : mem_rdata;

  assign mem_addr  = mem_req ? em.alu : '0;
  assign mem_wdata = mem_req ? (em.is_byte ? zext_byte(em.sdata) : em.sdata) : '0;
  assign mem_we    = mem_req & em.mem_write;
  assign mem_byte  = mem_req & em.is_byte;

  assign alu_result_mem = em.alu;
  assign rd_mem         = em.rd;
  assign reg_write_mem  = em.reg_write;

  // No request outstanding counts as idle for the timeout.
  mem_timeout_counter u_timeout (
    .clk    (clk),
    .reset  (reset),
    .count  (mem_req & ~mem_ack),
    .clear  (ack | ~mem_req),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mem_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (expire) begin
            state   <= ERROR;
            mem_err <= 1'b1;
          end else if (mem_req && !mem_ack) begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (ack) begin
            state <= IDLE;
          end else if (expire) begin
            state   <= ERROR;
            mem_err <= 1'b1;
          end
        end
        ERROR:   state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) em <= '0;
    else if (!stall)
      em <= '{alu: alu_result_ex, sdata: store_data_ex, rd: rd_ex,
              reg_write: reg_write_ex, mem_read: mem_read_ex,
              mem_write: mem_write_ex, is_byte: byte_ex};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_data      <= '0;
      rd_wb        <= '0;
      reg_write_wb <= 1'b0;
    end else if (stall) begin
      reg_write_wb <= 1'b0;
    end else begin
      wb_data      <= is_load ? load_data : em.alu;
      rd_wb        <= em.rd;
      reg_write_wb <= em.reg_write;
    end
  end
endmodule
